// File: rtl/ucore_mem_target.sv
// ucore_mem_target: memory-side target for the microcoded core's valid/ready bus.
//
// Holds a word-addressed RAM with per-byte write strobes, a programmable number of wait
// states and a 16-byte MMIO window:
//   MMIO+0x0 CONSOLE  write lane 0 -> tx_data/tx_valid, reads 0
//   MMIO+0x4 CYCLES   free-running cycle counter (read-only)
//   MMIO+0x8 STATUS   {31'b0, bus_err}; any write clears bus_err
//   MMIO+0xC          reads 0, writes ignored
// Any address outside RAM and the MMIO window completes normally but sets bus_err.
//
// Optional feature macro: UCORE_MEM_CYCLE_COUNTER_EN
//   defined   - CYCLES returns the running cycle counter
//   undefined - counter logic is absent, CYCLES reads 0 (still decoded, never an error)
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   mem_valid       request valid from the core
//   mem_ready       one-cycle completion pulse
//   mem_addr        byte address (bits [1:0] ignored)
//   mem_rdata       read data, valid while mem_ready=1
//   mem_wdata       write data
//   mem_wstrb       byte enables, 0 means read
//   tx_data         console byte
//   tx_valid        one-cycle strobe qualifying tx_data
//   bus_err         sticky decode-error flag
module ucore_mem_target #(
    parameter int unsigned DEPTH_WORDS = 81920,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        bus_err
);

    localparam int unsigned RamAw    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] RamBytes = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        mem_ready_q, mem_ready_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        bus_err_q, bus_err_d;
`ifdef UCORE_MEM_CYCLE_COUNTER_EN
    logic [31:0] cycles_q, cycles_d;
`endif

    logic [31:0] ram [DEPTH_WORDS];

    // The access happens on the edge that enters StResp. With zero wait states that edge is
    // also the accept edge, so the request fields come straight from the bus instead of the
    // latched copies.
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_wstrb;
    logic             access;
    logic             acc_write;
    logic             in_ram;
    logic             in_mmio;
    logic [RamAw-1:0] ram_idx;
    logic             ram_we;

    always_comb begin
        acc_addr  = (state_q == StIdle) ? mem_addr  : addr_q;
        acc_wdata = (state_q == StIdle) ? mem_wdata : wdata_q;
        acc_wstrb = (state_q == StIdle) ? mem_wstrb : wstrb_q;
        acc_write = |acc_wstrb;
        in_ram    = acc_addr < RamBytes;
        in_mmio   = acc_addr[31:4] == MMIO_BASE[31:4];
        ram_idx   = acc_addr[RamAw+1:2];
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        mem_ready_d = 1'b0;
        mem_rdata_d = mem_rdata_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = 1'b0;
        bus_err_d   = bus_err_q;
        access      = 1'b0;
        ram_we      = 1'b0;
`ifdef UCORE_MEM_CYCLE_COUNTER_EN
        cycles_d    = cycles_q + 32'd1;
`endif

        case (state_q)
            StIdle: begin
                // mem_ready_q keeps a request still held across the ready edge from being
                // accepted twice.
                if (mem_valid && !mem_ready_q) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StResp;
                        access  = 1'b1;
                    end else begin
                        state_d = StWait;
                        wait_d  = 4'(WAIT_CYCLES);
                    end
                end
            end
            StWait: begin
                wait_d = wait_q - 4'd1;
                if (wait_q == 4'd1) begin
                    state_d = StResp;
                    access  = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (access) begin
            mem_ready_d = 1'b1;
            mem_rdata_d = 32'd0;
            if (in_ram) begin
                if (acc_write) begin
                    ram_we = 1'b1;
                end else begin
                    mem_rdata_d = ram[ram_idx];
                end
            end else if (in_mmio) begin
                case (acc_addr[3:2])
                    2'd0: begin
                        if (acc_wstrb[0]) begin
                            tx_data_d  = acc_wdata[7:0];
                            tx_valid_d = 1'b1;
                        end
                    end
                    2'd1: begin
`ifdef UCORE_MEM_CYCLE_COUNTER_EN
                        if (!acc_write) begin
                            mem_rdata_d = cycles_q;
                        end
`endif
                    end
                    2'd2: begin
                        if (acc_write) begin
                            bus_err_d = 1'b0;
                        end else begin
                            mem_rdata_d = {31'd0, bus_err_q};
                        end
                    end
                    default: begin
                    end
                endcase
            end else begin
                bus_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wait_q      <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= 32'd0;
            tx_data_q   <= 8'd0;
            tx_valid_q  <= 1'b0;
            bus_err_q   <= 1'b0;
`ifdef UCORE_MEM_CYCLE_COUNTER_EN
            cycles_q    <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            bus_err_q   <= bus_err_d;
`ifdef UCORE_MEM_CYCLE_COUNTER_EN
            cycles_q    <= cycles_d;
`endif
        end
    end

    // RAM contents survive reset; a reset on the access edge drops the write.
    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wstrb[i]) begin
                    ram[ram_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_ucore_mem_target.sv
module tb_ucore_mem_target;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: WAIT_CYCLES=1 instance, index 1: WAIT_CYCLES=3 instance.
    logic [1:0]  rst_v;
    logic [1:0]  valid_v;
    logic [1:0]  ready_v;
    logic [1:0]  txv_v;
    logic [1:0]  err_v;
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    logic [31:0] rdata_v [2];
    logic [3:0]  wstrb_v [2];
    logic [7:0]  txd_v   [2];

    int n_cmp = 0;
    int n_err = 0;

    // Results of the last do_access call.
    logic [31:0] r_rd;
    int          r_lat;
    logic        r_txv;
    logic [7:0]  r_txd;
    logic        r_rdy_after;
    logic        r_txv_after;

    ucore_mem_target #(.DEPTH_WORDS(81920), .WAIT_CYCLES(1), .MMIO_BASE(32'h1000_0000)) dut (
        .clk       (clk),
        .rst       (rst_v[0]),
        .mem_valid (valid_v[0]),
        .mem_ready (ready_v[0]),
        .mem_addr  (addr_v[0]),
        .mem_rdata (rdata_v[0]),
        .mem_wdata (wdata_v[0]),
        .mem_wstrb (wstrb_v[0]),
        .tx_data   (txd_v[0]),
        .tx_valid  (txv_v[0]),
        .bus_err   (err_v[0])
    );

    ucore_mem_target #(.DEPTH_WORDS(81920), .WAIT_CYCLES(3), .MMIO_BASE(32'h1000_0000)) dut3 (
        .clk       (clk),
        .rst       (rst_v[1]),
        .mem_valid (valid_v[1]),
        .mem_ready (ready_v[1]),
        .mem_addr  (addr_v[1]),
        .mem_rdata (rdata_v[1]),
        .mem_wdata (wdata_v[1]),
        .mem_wstrb (wstrb_v[1]),
        .tx_data   (txd_v[1]),
        .tx_valid  (txv_v[1]),
        .bus_err   (err_v[1])
    );

    // Called #1 after a posedge; returns #1 after the edge that ends the ready cycle.
    task automatic do_access(input int d, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] ws);
        addr_v[d]  = a;
        wdata_v[d] = wd;
        wstrb_v[d] = ws;
        valid_v[d] = 1'b1;
        r_lat = -1;
        r_rd  = 32'd0;
        r_txv = 1'b0;
        r_txd = 8'd0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ready_v[d] === 1'b1) begin
                r_lat = i;
                r_rd  = rdata_v[d];
                r_txv = txv_v[d];
                r_txd = txd_v[d];
                break;
            end
        end
        n_cmp++;
        if (r_lat < 0) begin
            n_err++;
            $display("FAIL ready_timeout dut=%0d addr=%h got=no ready in 40 cycles", d, a);
        end
        @(posedge clk); #1;
        valid_v[d]  = 1'b0;
        wstrb_v[d]  = 4'd0;
        r_rdy_after = ready_v[d];
        r_txv_after = txv_v[d];
    endtask

    task automatic test_reset();
        rst_v = 2'b11;
        valid_v = 2'b00;
        for (int d = 0; d < 2; d++) begin
            addr_v[d] = 32'd0; wdata_v[d] = 32'd0; wstrb_v[d] = 4'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (ready_v[d] !== 1'b0) begin
                n_err++; $display("FAIL reset_ready dut=%0d got=%b exp=0", d, ready_v[d]);
            end
            n_cmp++;
            if (rdata_v[d] !== 32'd0) begin
                n_err++; $display("FAIL reset_rdata dut=%0d got=%h exp=0", d, rdata_v[d]);
            end
            n_cmp++;
            if (txd_v[d] !== 8'd0 || txv_v[d] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_tx dut=%0d got=%h/%b exp=00/0", d, txd_v[d], txv_v[d]);
            end
            n_cmp++;
            if (err_v[d] !== 1'b0) begin
                n_err++; $display("FAIL reset_bus_err dut=%0d got=%b exp=0", d, err_v[d]);
            end
        end
        rst_v = 2'b00;
    endtask

    task automatic test_rw_latency();
        do_access(0, 32'h100, 32'h1234_5678, 4'b1111);
        n_cmp++;
        if (r_lat !== 2) begin
            n_err++; $display("FAIL write_latency got=%0d exp=2", r_lat);
        end
        n_cmp++;
        if (r_rd !== 32'd0) begin
            n_err++; $display("FAIL write_rdata got=%h exp=0", r_rd);
        end
        do_access(0, 32'h100, 32'd0, 4'b0000);
        n_cmp++;
        if (r_lat !== 2) begin
            n_err++; $display("FAIL read_latency got=%0d exp=2", r_lat);
        end
        n_cmp++;
        if (r_rd !== 32'h1234_5678) begin
            n_err++; $display("FAIL read_0x100 got=%h exp=12345678", r_rd);
        end
        n_cmp++;
        if (r_rdy_after !== 1'b0) begin
            n_err++; $display("FAIL ready_width got=%b exp=0 after ready cycle", r_rdy_after);
        end
    endtask

    task automatic test_byte_lanes();
        do_access(0, 32'h104, 32'h0000_0000, 4'b1111);
        do_access(0, 32'h104, 32'hAABB_CCDD, 4'b0101);
        do_access(0, 32'h104, 32'd0, 4'b0000);
        n_cmp++;
        if (r_rd !== 32'h00BB_00DD) begin
            n_err++; $display("FAIL byte_lanes got=%h exp=00bb00dd", r_rd);
        end
        // Last word of RAM is in range.
        do_access(0, 32'h0004_FFFC, 32'hCAFE_F00D, 4'b1111);
        do_access(0, 32'h0004_FFFC, 32'd0, 4'b0000);
        n_cmp++;
        if (r_rd !== 32'hCAFE_F00D || err_v[0] !== 1'b0) begin
            n_err++;
            $display("FAIL ram_last_word got=%h err=%b exp=cafef00d err=0", r_rd, err_v[0]);
        end
    endtask

    task automatic test_console();
        do_access(0, 32'h1000_0000, 32'h0000_0041, 4'b0001);
        n_cmp++;
        if (r_txv !== 1'b1 || r_txd !== 8'h41) begin
            n_err++; $display("FAIL console_tx got=%b/%h exp=1/41", r_txv, r_txd);
        end
        n_cmp++;
        if (r_txv_after !== 1'b0) begin
            n_err++; $display("FAIL console_tx_width got=%b exp=0 after ready", r_txv_after);
        end
        do_access(0, 32'h1000_0000, 32'd0, 4'b0000);
        n_cmp++;
        if (r_rd !== 32'd0 || r_txv !== 1'b0) begin
            n_err++; $display("FAIL console_read got=%h txv=%b exp=0 txv=0", r_rd, r_txv);
        end
    endtask

    task automatic test_decode_err();
        do_access(0, 32'h1000_0004, 32'd0, 4'b0000);
        n_cmp++;
        if (err_v[0] !== 1'b0) begin
            n_err++; $display("FAIL cycles_no_err got=%b exp=0", err_v[0]);
        end
`ifndef UCORE_MEM_CYCLE_COUNTER_EN
        n_cmp++;
        if (r_rd !== 32'd0) begin
            n_err++; $display("FAIL cycles_absent got=%h exp=0", r_rd);
        end
`endif
        do_access(0, 32'h1000_000C, 32'h1, 4'b1111);
        n_cmp++;
        if (err_v[0] !== 1'b0) begin
            n_err++; $display("FAIL mmio_c_no_err got=%b exp=0", err_v[0]);
        end
        do_access(0, 32'h2000_0000, 32'd0, 4'b0000);
        n_cmp++;
        if (r_rd !== 32'd0 || r_lat !== 2) begin
            n_err++; $display("FAIL err_read got=%h lat=%0d exp=0 lat=2", r_rd, r_lat);
        end
        n_cmp++;
        if (err_v[0] !== 1'b1) begin
            n_err++; $display("FAIL err_set got=%b exp=1", err_v[0]);
        end
        do_access(0, 32'h1000_0008, 32'd0, 4'b0000);
        n_cmp++;
        if (r_rd !== 32'h1) begin
            n_err++; $display("FAIL status_read got=%h exp=1", r_rd);
        end
        do_access(0, 32'h1000_0008, 32'd0, 4'b1111);
        n_cmp++;
        if (err_v[0] !== 1'b0) begin
            n_err++; $display("FAIL status_clear got=%b exp=0", err_v[0]);
        end
        // One past the last RAM word is a decode error.
        do_access(0, 32'h0005_0000, 32'h5, 4'b1111);
        n_cmp++;
        if (err_v[0] !== 1'b1) begin
            n_err++; $display("FAIL ram_end_err got=%b exp=1", err_v[0]);
        end
        do_access(0, 32'h1000_0008, 32'd0, 4'b0001);
    endtask

    task automatic test_back_to_back();
        int lat2;
        int extra;
        addr_v[0]  = 32'h100;
        wstrb_v[0] = 4'd0;
        valid_v[0] = 1'b1;
        r_lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ready_v[0] === 1'b1) begin r_lat = i; r_rd = rdata_v[0]; break; end
        end
        n_cmp++;
        if (r_lat !== 2 || r_rd !== 32'h1234_5678) begin
            n_err++; $display("FAIL b2b_first got=lat %0d %h exp=lat 2 12345678", r_lat, r_rd);
        end
        // Valid stays high over the ready edge; present the next request right after.
        @(posedge clk); #1;
        n_cmp++;
        if (ready_v[0] !== 1'b0) begin
            n_err++; $display("FAIL b2b_double_accept got=%b exp=0", ready_v[0]);
        end
        addr_v[0] = 32'h104;
        lat2 = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ready_v[0] === 1'b1) begin lat2 = i; r_rd = rdata_v[0]; break; end
        end
        n_cmp++;
        if (lat2 !== 2 || r_rd !== 32'h00BB_00DD) begin
            n_err++; $display("FAIL b2b_second got=lat %0d %h exp=lat 2 00bb00dd", lat2, r_rd);
        end
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        extra = (ready_v[0] === 1'b1) ? 1 : 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ready_v[0] === 1'b1) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_err++; $display("FAIL b2b_extra_ready got=%0d exp=0", extra);
        end
    endtask

    task automatic test_reset_mid_wait();
        int seen;
        do_access(1, 32'h200, 32'h5555_AAAA, 4'b1111);
        n_cmp++;
        if (r_lat !== 4) begin
            n_err++; $display("FAIL wait3_latency got=%0d exp=4", r_lat);
        end
        addr_v[1]  = 32'h200;
        wdata_v[1] = 32'hDEAD_BEEF;
        wstrb_v[1] = 4'b1111;
        valid_v[1] = 1'b1;
        seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ready_v[1] === 1'b1) seen++;
        end
        rst_v[1]   = 1'b1;
        valid_v[1] = 1'b0;
        wstrb_v[1] = 4'd0;
        @(posedge clk); #1;
        rst_v[1] = 1'b0;
        // Cycle counter is zero now; ten cycles later issue the CYCLES read.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ready_v[1] === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++; $display("FAIL rst_mid_wait_ready got=%0d exp=0", seen);
        end
        do_access(1, 32'h1000_0004, 32'd0, 4'b0000);
`ifdef UCORE_MEM_CYCLE_COUNTER_EN
        n_cmp++;
        if (r_rd < 32'd10 || r_rd > 32'd14) begin
            n_err++; $display("FAIL cycles_value got=%0d exp=10..14", r_rd);
        end
`else
        n_cmp++;
        if (r_rd !== 32'd0) begin
            n_err++; $display("FAIL cycles_absent3 got=%h exp=0", r_rd);
        end
`endif
        do_access(1, 32'h200, 32'd0, 4'b0000);
        n_cmp++;
        if (r_rd !== 32'h5555_AAAA) begin
            n_err++; $display("FAIL rst_mid_wait_ram got=%h exp=5555aaaa", r_rd);
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_rw_latency();
        test_byte_lanes();
        test_console();
        test_decode_err();
        test_back_to_back();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ucore_mem_target.md
Name: ucore_mem_target

Overview:
- Memory-side target for the microcoded core's valid/ready bus; consumes every request the core issues.
- Contains a word-addressed RAM with per-byte write strobes, programmable wait states and a small MMIO window.
- MMIO window holds a console TX port, a free-running cycle counter and a bus-error status register.
- Sits directly downstream of the core, which has one outstanding request at most.

Parameters:
- DEPTH_WORDS, 81920: RAM size in 32-bit words. Covers byte addresses 0x0000_0000..0x0004_FFFF, including the initial stack top 0x0005_0000-4.
- WAIT_CYCLES, 1: extra cycles inserted between request acceptance and mem_ready. Legal range 0..15.
- MMIO_BASE, 32'h1000_0000: base byte address of the MMIO window. Window size is 16 bytes.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_valid  in  1  request valid from core
- mem_ready  out  1  one-cycle completion pulse
- mem_addr  in  32  byte address; bits [1:0] ignored
- mem_rdata  out  32  read data, valid while mem_ready=1
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte enables; 0 means read
- tx_data  out  8  console byte
- tx_valid  out  1  one-cycle strobe, tx_data valid
- bus_err  out  1  sticky decode-error flag

Behaviour:
- Reset (rst=1 at a posedge) forces these values:
  - mem_ready=0, mem_rdata=0, tx_data=0, tx_valid=0, bus_err=0.
  - FSM goes to IDLE; wait counter and cycle counter are cleared.
  - RAM contents are not cleared.
- Reset mid-transaction abandons the access: no RAM write, no tx_valid, no mem_ready.
- FSM states:
  - IDLE: when mem_valid=1 and mem_ready=0, latch mem_addr, mem_wdata and mem_wstrb, load the counter with WAIT_CYCLES, then go to WAIT, or to RESP if WAIT_CYCLES=0.
  - WAIT: decrement the counter. When it reaches 0, go to RESP.
  - RESP: mem_ready=1 for exactly this cycle, then go to IDLE.
- The core deasserts mem_valid on the edge that ends the ready cycle. IDLE must never accept on that same edge; the mem_ready=0 qualifier guarantees this.
- All outputs are registered. The access is performed on the edge that enters RESP:
  - RAM read: mem_rdata = RAM[addr[31:2]].
  - RAM write: each byte lane i with wstrb[i]=1 is written. For writes, mem_rdata=0.
- Latency: with mem_valid first high in cycle N, mem_ready is high in cycle N+1+WAIT_CYCLES.
- Address decode is on the latched address:
  - RAM region: addr < DEPTH_WORDS*4.
  - MMIO+0x0 CONSOLE: a write with wstrb[0]=1 sets tx_data=wdata[7:0] and tx_valid=1 in the RESP cycle only. Reads return 0.
  - MMIO+0x4 CYCLES: reads return the 32-bit cycle counter value; writes are ignored. The counter increments every non-reset cycle and wraps 0xFFFF_FFFF→0.
  - MMIO+0x8 STATUS: reads return {31'b0, bus_err}. Any write clears bus_err.
  - MMIO+0xC: reads 0, writes ignored, no error.
  - Any other address: reads return 0, writes are dropped, bus_err is set to 1. mem_ready still completes normally, so the core never hangs.
- Simultaneous error set and STATUS write cannot occur, because only one access is in flight.
- mem_wstrb is not checked against alignment; only the enabled lanes are written.

Optional Feature:
- Macro: UCORE_MEM_CYCLE_COUNTER_EN.
- Defined: the CYCLES register behaves as described above.
- Undefined: the counter logic is absent and reads of MMIO+0x4 return 0. This address is still decoded and never sets bus_err.

Test Plan:
- WAIT_CYCLES=1: write 0x12345678 to 0x100 (wstrb=1111), then read 0x100 → mem_ready high exactly 2 cycles after mem_valid rises, one cycle wide; read returns 0x12345678.
- Byte lanes: write 0xAABBCCDD with wstrb=0101 over 0x00000000 at 0x104 → read returns 0x00BB00DD.
- Console: write 0x00000041 to 0x1000_0000 → tx_valid=1 and tx_data=0x41 in the mem_ready cycle only; a following read of 0x1000_0000 returns 0.
- Decode error: read 0x2000_0000 → rdata 0 and mem_ready pulse, bus_err=1. Read 0x1000_0008 → 0x1. Write there → bus_err=0.
- Back-to-back: mem_valid held high across the ready edge and reasserted next cycle → exactly one mem_ready per request, no double accept.
- Reset mid-WAIT with WAIT_CYCLES=3, on a write to 0x200 → no mem_ready, RAM[0x80] unchanged. With UCORE_MEM_CYCLE_COUNTER_EN, a read of 0x1000_0004 issued 10 cycles after reset release returns a value within 10..(10+WAIT_CYCLES+1).
